// File: rtl/mdu_ctrl_pkg.sv
// ============================================================================
// Module   : mdu_ctrl_pkg
// Purpose  : Shared definitions for the multiply/divide controller: the
//            mult/div subset of the ALU control codes, FSM state encoding,
//            multiply latency bounds and small decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_ctrl_pkg;

  // Mult/div subset of the EX-stage ALU control encoding
  localparam logic [4:0] ALU_SIGNED_MULT   = 5'h18;
  localparam logic [4:0] ALU_UNSIGNED_MULT = 5'h19;
  localparam logic [4:0] ALU_SIGNED_DIV    = 5'h1A;
  localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'h1B;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Multiply latency bounds
  localparam int MUL_CYCLES_MIN     = 1;
  localparam int MUL_CYCLES_DEFAULT = 2;

  // Latched operation attributes
  typedef struct packed {
    logic is_div;
    logic sgn;
  } mdu_op_t;

  function automatic logic is_mdu_op(input logic [4:0] code);
    return (code == ALU_SIGNED_MULT) || (code == ALU_UNSIGNED_MULT) ||
           (code == ALU_SIGNED_DIV)  || (code == ALU_UNSIGNED_DIV);
  endfunction

  function automatic mdu_op_t decode_op(input logic [4:0] code);
    mdu_op_t op;
    op.is_div = (code == ALU_SIGNED_DIV)  || (code == ALU_UNSIGNED_DIV);
    op.sgn    = (code == ALU_SIGNED_DIV)  || (code == ALU_SIGNED_MULT);
    return op;
  endfunction

  // Magnitude of a value, treating it as two's complement only when sgn is set
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_ctrl_if.sv
// ============================================================================
// Module   : mdu_ctrl_if
// Purpose  : Pipeline <-> multiply/divide controller bundle.
//   master : pipeline side (drives start/alu_control/src_a/src_b/flush)
//   slave  : controller side (drives stall/busy/valid_out/hi_out/lo_out)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_ctrl_if;
  logic        start;
  logic [4:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        valid_out;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, alu_control, src_a, src_b, flush,
    input  stall, busy, valid_out, hi_out, lo_out
  );

  modport slave (
    input  start, alu_control, src_a, src_b, flush,
    output stall, busy, valid_out, hi_out, lo_out
  );
endinterface

`default_nettype wire

// File: rtl/mdu_ctrl_div_iter.sv
// ============================================================================
// Module   : div_iter
// Purpose  : One combinational restoring-division step.
//   pair_in  [63:0] : remainder (upper word) : quotient/dividend (lower word)
//   divisor  [31:0] : divisor magnitude
//   pair_out [63:0] : pair after shift, trial subtract and restore
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter (
  input  logic [63:0] pair_in,
  input  logic [31:0] divisor,
  output logic [63:0] pair_out
);

  logic [32:0] w_trial;
  logic [32:0] w_diff;

  // Remainder shifted left with the next dividend bit; 33 bits so the
  // doubled remainder never loses its top bit.
  assign w_trial = pair_in[63:31];
  assign w_diff  = w_trial - {1'b0, divisor};

  // Borrow (bit 32) means the trial went negative: keep the shifted remainder.
  assign pair_out = w_diff[32] ? {w_trial[31:0], pair_in[30:0], 1'b0}
                               : {w_diff[31:0],  pair_in[30:0], 1'b1};

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : Multi-cycle multiply/divide controller for the EX stage. Stalls
//            the pipeline while computing and delivers a HI/LO result pair.
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : mdu_ctrl_if.slave (start/alu_control/src_a/src_b/flush in,
//            stall/busy/valid_out/hi_out/lo_out out)
// Options  : MDU_DIV_FAST_EN - divides by zero or with |dividend| < |divisor|
//            finish right after the setup cycle instead of iterating.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  mdu_ctrl_if.slave  bus
);

  localparam int          MCW      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_CYCLES - 1);

  logic [1:0]     r_state;
  logic [31:0]    r_a;
  logic [31:0]    r_b;
  mdu_op_t        r_op;
  logic [MCW-1:0] r_mul_cnt;
  logic [4:0]     r_cnt;
  logic [63:0]    r_pair;
  logic [31:0]    r_hi;
  logic [31:0]    r_lo;

  logic           w_accept;
  mdu_op_t        w_new_op;
  logic [31:0]    w_ma;
  logic [31:0]    w_mb;
  logic           w_msgn;
  logic [63:0]    w_prod;
  logic [31:0]    w_a_mag;
  logic [31:0]    w_b_mag;
  logic [63:0]    w_pair_in;
  logic [63:0]    w_pair_out;
  logic           w_div_zero;
  logic [31:0]    w_quot;
  logic [31:0]    w_rem;
  logic           w_fast;

  assign w_new_op = decode_op(bus.alu_control);
  assign w_accept = (r_state == ST_IDLE) && bus.start &&
                    is_mdu_op(bus.alu_control) && !bus.flush;

  // Gated by resetn so stall drops the moment reset asserts, even while the
  // pipeline is still presenting start.
  assign bus.stall     = resetn && (w_accept || (r_state == ST_MUL) || (r_state == ST_DIV));
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.valid_out = (r_state == ST_DONE);
  assign bus.hi_out    = r_hi;
  assign bus.lo_out    = r_lo;

  // Multiplier operands come straight from the bus when a single-cycle
  // multiply completes in its accept cycle, otherwise from the latches.
  assign w_ma   = (r_state == ST_IDLE) ? bus.src_a   : r_a;
  assign w_mb   = (r_state == ST_IDLE) ? bus.src_b   : r_b;
  assign w_msgn = (r_state == ST_IDLE) ? w_new_op.sgn : r_op.sgn;
  assign w_prod = {{32{w_msgn & w_ma[31]}}, w_ma} * {{32{w_msgn & w_mb[31]}}, w_mb};

  // Divider datapath; the first iteration seeds the pair from the magnitudes.
  assign w_a_mag    = mag(r_a, r_op.sgn);
  assign w_b_mag    = mag(r_b, r_op.sgn);
  assign w_pair_in  = (r_cnt == 5'd0) ? {32'd0, w_a_mag} : r_pair;
  assign w_div_zero = (r_b == 32'd0);

  div_iter u_div_iter (
    .pair_in  (w_pair_in),
    .divisor  (w_b_mag),
    .pair_out (w_pair_out)
  );

  assign w_quot = (r_op.sgn && (r_a[31] ^ r_b[31])) ? (~w_pair_out[31:0] + 32'd1)
                                                     : w_pair_out[31:0];
  assign w_rem  = (r_op.sgn && r_a[31]) ? (~w_pair_out[63:32] + 32'd1)
                                        : w_pair_out[63:32];

`ifdef MDU_DIV_FAST_EN
  assign w_fast = (r_cnt == 5'd0) && (w_div_zero || (w_a_mag < w_b_mag));
`else
  assign w_fast = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_mul_cnt <= '0;
      r_cnt     <= '0;
      r_pair    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (bus.flush) begin
      // Cancel without touching the result registers
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a   <= bus.src_a;
            r_b   <= bus.src_b;
            r_op  <= w_new_op;
            r_cnt <= '0;
            if (w_new_op.is_div) begin
              r_state <= ST_DIV;
            end else if (MUL_CYCLES == 1) begin
              r_state <= ST_DONE;
              r_hi    <= w_prod[63:32];
              r_lo    <= w_prod[31:0];
            end else begin
              // The accept cycle counts as multiply cycle 0
              r_state   <= ST_MUL;
              r_mul_cnt <= MCW'(1);
            end
          end
        end
        ST_MUL: begin
          if (r_mul_cnt == MUL_LAST) begin
            r_state <= ST_DONE;
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
          end else begin
            r_mul_cnt <= r_mul_cnt + MCW'(1);
          end
        end
        ST_DIV: begin
          if (w_fast) begin
            r_state <= ST_DONE;
            r_hi    <= r_a;
            r_lo    <= w_div_zero ? 32'hFFFF_FFFF : 32'd0;
          end else if (r_cnt == 5'd31) begin
            r_state <= ST_DONE;
            if (w_div_zero) begin
              r_hi <= r_a;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end else begin
            r_pair <= w_pair_out;
            r_cnt  <= r_cnt + 5'd1;
          end
        end
        ST_DONE: begin
          // start still high here belongs to the completing instruction
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
